display_scan_ctrl: RTL and testbench
====================================

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 The block SHALL have parameter CLK_DIV, default 100000, giving the clock cycles per digit display slot (legal: >=2).
REQ-003 The block SHALL have parameter BLANK_CYCLES, default 1000, giving the clock cycles of the blanking gap between slots (legal: >=1).
REQ-004 Port list (name  direction  width  meaning):
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- digit_a  in  4  hex value for digit 0 (an[0], least significant)
- digit_b  in  4  hex value for digit 1 (an[1])
- digit_c  in  4  hex value for digit 2 (an[2])
- digit_d  in  4  hex value for digit 3 (an[3], most significant)
- load  in  1  single-cycle strobe; captures digit_a..digit_d
- enable  in  1  1 = drive the display; 0 = force blank
- lz_suppress  in  1  1 = blank leading zeros on digits d, c, b
- segs  out  7  active-low segments {g,f,e,d,c,b,a}, registered
- an  out  4  active-low anode selects, registered

Function
REQ-005 segs encoding for 0-F SHALL be: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
REQ-006 The FSM SHALL have two states: BLANK and DISPLAY.
- BLANK lasts exactly BLANK_CYCLES cycles, then goes to DISPLAY.
- DISPLAY lasts exactly CLK_DIV cycles, then goes to BLANK.
REQ-007 A 2-bit slot index SHALL advance on every DISPLAY->BLANK transition, in the order 0,1,2,3,0, wrapping modulo 4.
- One frame = 4*(CLK_DIV+BLANK_CYCLES) cycles.
REQ-008 In BLANK, outputs SHALL be an=1111 and segs=1111111.
REQ-009 In DISPLAY with slot i, outputs SHALL be:
- an = 0 on bit i only, 1 on the other bits;
- segs = encoding of display-buffer digit i.
REQ-010 Outputs SHALL be registered, reflecting the state, index and buffer of the previous cycle (one-cycle output latency).
REQ-011 On a cycle with load=1, a shadow register SHALL capture digit_a..digit_d and set a pending flag.
REQ-012 On the BLANK->DISPLAY transition into slot 0 (frame boundary) with pending=1:
- the display buffer SHALL copy the shadow register;
- pending SHALL clear.
- The buffer SHALL never change at any other time (no mid-frame tearing).
REQ-013 If load coincides with a frame boundary:
- the transfer SHALL use the pre-edge shadow contents;
- the shadow SHALL take the new inputs;
- pending SHALL remain 1.
REQ-014 Multiple loads within one frame SHALL be allowed; the last one wins.
REQ-015 With lz_suppress=1, a suppressed slot SHALL output an=1111 and segs=1111111 for its DISPLAY period. Suppression rules on buffer contents:
- d is suppressed when d==0;
- c is suppressed when d==0 and c==0;
- b is suppressed when d, c and b are all 0;
- a is never suppressed.
REQ-016 With enable=0:
- outputs SHALL be an=1111 and segs=1111111 from the next edge;
- the FSM, counters, index and load path SHALL continue running, so re-enabling resumes in phase.

Reset
REQ-017 On reset=1 at a clock edge, the block SHALL set:
- state = BLANK, cycle counter = 0, index = 0;
- shadow = 0, buffer = 0, pending = 0;
- an = 1111, segs = 1111111.
REQ-018 Reset SHALL take priority over load, enable and all FSM activity.
REQ-019 Reset asserted mid-operation SHALL abort the current slot, with outputs blank at the next edge.
REQ-020 After reset release, the first DISPLAY slot SHALL be slot 0 showing 0 (segs=1000000), starting BLANK_CYCLES cycles later.

Verification (CLK_DIV=4, BLANK_CYCLES=2, enable=1 unless stated)
REQ-021 Reset, then release -> an=1111, segs=1111111 for 2 cycles, then an=1110, segs=1000000 for 4 cycles, then 2 blank cycles.
REQ-022 load with a=1, b=2, c=3, d=4, then wait for the frame boundary -> four slots, each 4 cycles with 2 blank cycles between:
- an=1110 with segs=1111001;
- an=1101 with segs=0100100;
- an=1011 with segs=0110000;
- an=0111 with segs=0011001.
REQ-023 lz_suppress=1, load a=0, b=5, c=0, d=0 -> slots c and d fully blank (an=1111); slot b shows 0010010; slot a shows 1000000.
REQ-024 load a new value during slot 1 -> slots 2 and 3 of that frame show the old values; the new values appear from the next slot 0. Also: load exactly at a frame boundary -> pending stays 1 and the new values appear one frame later.
REQ-025 Drop enable for 3 cycles mid-slot -> an=1111 starting the next edge; on restore, the same slot and cycle count continue, and the frame length is unchanged.
REQ-026 Assert reset during slot 2 DISPLAY -> blank outputs at the next edge and the buffer cleared; after release, REQ-021 timing repeats.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with blanking gaps between
// digit slots and a frame-synchronous, tear-free display buffer update.
//
// state   | meaning
// BLANK   | all anodes off for BLANK_CYCLES cycles before the next slot
// DISPLAY | anode idx driven with its digit for CLK_DIV cycles
module display_scan_ctrl #(
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit_a,
  input  logic [3:0] digit_b,
  input  logic [3:0] digit_c,
  input  logic [3:0] digit_d,
  input  logic       load,
  input  logic       enable,
  input  logic       lz_suppress,
  output logic [6:0] segs,
  output logic [3:0] an
);

  localparam int MAXC = (CLK_DIV > BLANK_CYCLES) ? CLK_DIV : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC);
  localparam logic [CW-1:0] DISP_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic {BLANK, DISPLAY} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [15:0]   shadow;
  logic [15:0]   dbuf;
  logic          pending;
  logic [3:0]    cur_digit;
  logic          suppress;
  logic          frame_edge;

  function automatic logic [6:0] seg_enc(input logic [3:0] v);
    case (v)
      4'h0: seg_enc = 7'b1000000;
      4'h1: seg_enc = 7'b1111001;
      4'h2: seg_enc = 7'b0100100;
      4'h3: seg_enc = 7'b0110000;
      4'h4: seg_enc = 7'b0011001;
      4'h5: seg_enc = 7'b0010010;
      4'h6: seg_enc = 7'b0000010;
      4'h7: seg_enc = 7'b1111000;
      4'h8: seg_enc = 7'b0000000;
      4'h9: seg_enc = 7'b0010000;
      4'hA: seg_enc = 7'b0001000;
      4'hB: seg_enc = 7'b0000011;
      4'hC: seg_enc = 7'b1000110;
      4'hD: seg_enc = 7'b0100001;
      4'hE: seg_enc = 7'b0000110;
      default: seg_enc = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    cur_digit  = dbuf[{idx, 2'b00} +: 4];
    suppress   = 1'b0;
    case (idx)
      2'd3: suppress = lz_suppress && (dbuf[15:12] == 4'h0);
      2'd2: suppress = lz_suppress && (dbuf[15:8] == 8'h00);
      2'd1: suppress = lz_suppress && (dbuf[15:4] == 12'h000);
      default: suppress = 1'b0;
    endcase
    // The buffer may only change on entry to slot 0, so a frame never tears.
    frame_edge = (state == BLANK) && (cnt == BLANK_LAST) && (idx == 2'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= BLANK;
      cnt     <= '0;
      idx     <= 2'd0;
      shadow  <= '0;
      dbuf    <= '0;
      pending <= 1'b0;
      an      <= 4'b1111;
      segs    <= 7'b1111111;
    end else begin
      case (state)
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state <= DISPLAY;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (cnt == DISP_LAST) begin
            state <= BLANK;
            cnt   <= '0;
            idx   <= idx + 2'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase

      if (frame_edge && pending) begin
        dbuf    <= shadow;
        pending <= 1'b0;
      end
      // A load on the frame edge wins the pending flag; the transfer above
      // still takes the old shadow.
      if (load) begin
        shadow  <= {digit_d, digit_c, digit_b, digit_a};
        pending <= 1'b1;
      end

      if (!enable || state == BLANK || suppress) begin
        an   <= 4'b1111;
        segs <= 7'b1111111;
      end else begin
        an   <= ~(4'b0001 << idx);
        segs <= seg_enc(cur_digit);
      end
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: directed scenarios plus random traffic, all
// compared against a cycle-count based reference of the scan schedule.
module tb_display_scan_ctrl;

  localparam int CLK_DIV = 4;
  localparam int BLANK   = 2;
  localparam int P       = CLK_DIV + BLANK;
  localparam int F       = 4 * P;

  localparam logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  localparam logic [3:0] REL_AN [8] = '{
    4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF};

  logic       clk = 1'b0;
  logic       reset, load, enable, lz_suppress;
  logic [3:0] digit_a, digit_b, digit_c, digit_d;
  logic [6:0] segs;
  logic [3:0] an;

  int n_checks = 0;
  int n_fail   = 0;

  // reference: k = edges since the reset edge; buffer/shadow/pending as plain values
  int          k = 0;
  logic [15:0] m_shadow = '0, m_buf = '0;
  logic        m_pend = 1'b0;
  logic        en_v = 1'b1, lz_v = 1'b0;

  display_scan_ctrl #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK)) dut (
    .clk(clk), .reset(reset),
    .digit_a(digit_a), .digit_b(digit_b), .digit_c(digit_c), .digit_d(digit_d),
    .load(load), .enable(enable), .lz_suppress(lz_suppress),
    .segs(segs), .an(an));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic ld, input logic [15:0] dig);
    logic [3:0] e_an;
    logic [6:0] e_segs;
    int s, slot;
    bit sup;
    reset = r; load = ld; enable = en_v; lz_suppress = lz_v;
    {digit_d, digit_c, digit_b, digit_a} = dig;
    @(posedge clk);
    e_an = 4'hF;
    e_segs = 7'h7F;
    if (r) begin
      k = 0; m_shadow = '0; m_buf = '0; m_pend = 1'b0;
    end else begin
      s = k % P;
      slot = (k / P) % 4;
      sup = 1'b0;
      if (lz_v && slot > 0) begin
        sup = 1'b1;
        for (int j = slot; j < 4; j++) if (m_buf[4*j +: 4] != 4'h0) sup = 1'b0;
      end
      if (en_v && s >= BLANK && !sup) begin
        e_an = ~(4'b0001 << slot);
        e_segs = SEG[m_buf[4*slot +: 4]];
      end
      k++;
      if (k % F == BLANK && m_pend) begin m_buf = m_shadow; m_pend = 1'b0; end
      if (ld) begin m_shadow = dig; m_pend = 1'b1; end
    end
    #1;
    chk("an", {28'h0, an}, {28'h0, e_an});
    chk("segs", {25'h0, segs}, {25'h0, e_segs});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0);
  endtask

  task automatic run_to(input int pos);
    for (int i = 0; i < F + 1 && (k % F) != pos; i++) step(1'b0, 1'b0, 16'h0);
  endtask

  task automatic reset_release_check();
    step(1'b1, 1'b0, 16'h0);
    chk("rst_an", {28'h0, an}, 32'hF);
    chk("rst_segs", {25'h0, segs}, 32'h7F);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 16'h0);
      chk("rel_an", {28'h0, an}, {28'h0, REL_AN[i]});
      if (REL_AN[i] == 4'hE) chk("rel_segs", {25'h0, segs}, 32'h40);
    end
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; enable = 1'b1; lz_suppress = 1'b0;
    {digit_d, digit_c, digit_b, digit_a} = 16'h0;
    reset_release_check();

    // digits a=1 b=2 c=3 d=4, two full frames
    step(1'b0, 1'b1, 16'h4321);
    idle(2 * F);

    // leading-zero suppression, d=0 c=0 b=5 a=0
    lz_v = 1'b1;
    step(1'b0, 1'b1, 16'h0050);
    idle(2 * F);
    lz_v = 1'b0;

    // load during slot 1, then load exactly on the frame boundary
    run_to(P + BLANK + 1);
    step(1'b0, 1'b1, 16'h9876);
    idle(F);
    run_to(BLANK - 1);
    step(1'b0, 1'b1, 16'hABCD);
    idle(2 * F);

    // enable dropped for 3 cycles mid-slot
    run_to(P + BLANK + 1);
    en_v = 1'b0;
    idle(3);
    en_v = 1'b1;
    idle(F);

    // reset during slot 2 display
    run_to(2 * P + BLANK + 1);
    reset_release_check();
    idle(F);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) en_v = ~en_v;
      if ($urandom_range(0, 49) == 0) lz_v = ~lz_v;
      step($urandom_range(0, 499) == 0, $urandom_range(0, 9) == 0,
           16'($urandom_range(0, 1) ? $urandom : $urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
